// File: rtl/result_serializer_if.sv
// Handshake and result-bus bundle between a compressor harness and the serializer.
interface result_serializer_if #(
  parameter int WIDTH = 58
);
  logic             start;
  logic [WIDTH-1:0] dst;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, dst, sout_ready,
    input  sout, sout_valid, busy, done
  );

  modport slave (
    input  start, dst, sout_ready,
    output sout, sout_valid, busy, done
  );
endinterface

// File: rtl/result_serializer.sv
// Captures a wide result bus after a settle delay and streams it LSB-first.
// RESULT_SERIALIZER_PARITY_EN appends an even-parity beat to each frame.
module result_serializer #(
  parameter int WIDTH  = 58,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 6
) (
  input logic          clk,
  input logic          rst,
  result_serializer_if.slave io
);

  localparam logic [7:0] SETTLE_M1 =
    (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SHIFT,
`ifdef RESULT_SERIALIZER_PARITY_EN
    S_PARITY,
`endif
    S_DONE
  } state_t;

  state_t           state_q;
  logic [7:0]       dly_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic             sout_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  logic             accept;
  logic             capture;
  logic [WIDTH-1:0] shreg_d;

  assign accept  = valid_q & io.sout_ready;
  assign shreg_d = shreg_q >> 1;
  assign capture =
    ((state_q == S_IDLE) && io.start && (SETTLE == 0)) ||
    ((state_q == S_SETTLE) && (dly_q == 8'd0));

  assign io.sout       = sout_q;
  assign io.sout_valid = valid_q;
  assign io.busy       = busy_q;
  assign io.done       = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dly_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RESULT_SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (io.start) begin
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
            dly_q   <= SETTLE_M1;
          end
        end
        S_SETTLE: begin
          dly_q <= dly_q - 8'd1;
        end
        S_SHIFT: begin
          if (accept) begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_q + CNT_W'(1);
            sout_q   <= shreg_d[0];
`ifdef RESULT_SERIALIZER_PARITY_EN
            par_q    <= par_q ^ shreg_q[0];
            if (bitcnt_q == LAST) begin
              state_q <= S_PARITY;
              sout_q  <= par_q ^ shreg_q[0];
            end
`else
            if (bitcnt_q == LAST) begin
              state_q <= S_DONE;
              sout_q  <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
`endif
          end
        end
`ifdef RESULT_SERIALIZER_PARITY_EN
        S_PARITY: begin
          if (accept) begin
            state_q <= S_DONE;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      // capture overrides the IDLE/SETTLE transitions above
      if (capture) begin
        state_q  <= S_SHIFT;
        shreg_q  <= io.dst;
        bitcnt_q <= '0;
        sout_q   <= io.dst[0];
        valid_q  <= 1'b1;
`ifdef RESULT_SERIALIZER_PARITY_EN
        par_q    <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer (WIDTH=58, SETTLE=2).
module tb_result_serializer;

  localparam int W = 58;
`ifdef RESULT_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  // done visible after edge SETTLE+NB, counting the start edge as 0
  localparam int DONE_EDGE = 2 + NB;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  result_serializer_if #(.WIDTH(W)) io ();

  result_serializer #(
    .WIDTH(W), .SETTLE(2), .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  task automatic stream(
    input  logic [W-1:0] d,
    input  logic [W-1:0] alt,
    input  int           rnd,
    input  int           p1,
    input  int           p2,
    output logic [63:0]  bits,
    output int           nb,
    output int           nd,
    output int           de
  );
    logic prev_stall;
    logic prev_sout;
    int   e;
    bits = '0; nb = 0; nd = 0; de = -1;
    prev_stall = 1'b0; prev_sout = 1'b0;
    io.dst = d;
    io.start = 1'b1;
    io.sout_ready = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    e = 0;
    checks++;
    if (io.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got %b want 1", io.busy);
    end
    while (1) begin
      if (io.done === 1'b1) begin
        nd++;
        if (de < 0) de = e;
      end
      if (io.sout_valid === 1'b1) begin
        io.dst = alt;
        if (prev_stall) begin
          checks++;
          if (io.sout !== prev_sout) begin
            errors++;
            $display("FAIL stall_stable got %b want %b", io.sout, prev_sout);
          end
        end
      end else begin
        checks++;
        if (io.sout !== 1'b0) begin
          errors++;
          $display("FAIL sout_idle_zero got %b want 0", io.sout);
        end
      end
      io.start = (nb == p1 || nb == p2) ? 1'b1 : 1'b0;
      io.sout_ready = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (io.sout_valid === 1'b1 && io.sout_ready) begin
        if (nb < 64) bits[nb] = io.sout;
        nb++;
      end
      prev_stall = (io.sout_valid === 1'b1) && !io.sout_ready;
      prev_sout  = io.sout;
      if (de >= 0 && e >= de + 2) break;
      if (e > 3000) begin
        checks++; errors++;
        $display("FAIL stream_timeout got %0d beats want done", nb);
        break;
      end
      @(posedge clk); #1;
      e++;
    end
    io.start = 1'b0;
    io.sout_ready = 1'b1;
  endtask

  task automatic check_frame(
    input string        nm,
    input logic [W-1:0] d,
    input logic [63:0]  bits,
    input int           nb,
    input int           nd
  );
    checks++;
    if (bits[W-1:0] !== d) begin
      errors++;
      $display("FAIL %s_bits got %h want %h", nm, bits[W-1:0], d);
    end
    checks++;
    if (nb !== NB) begin
      errors++;
      $display("FAIL %s_beats got %0d want %0d", nm, nb, NB);
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL %s_done_count got %0d want 1", nm, nd);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    logic [63:0]  bits;
    int nb, nd, de;
    d = 58'h2DE_ADBE_EF12_3456;
    rst = 1'b1;
    io.start = 1'b0;
    io.dst = '0;
    io.sout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({io.sout, io.sout_valid, io.busy, io.done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000",
               {io.sout, io.sout_valid, io.busy, io.done});
    end
    rst = 1'b0;
    io.dst = d;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    checks++;
    if ({io.sout_valid, io.sout} !== {1'b1, d[20]}) begin
      errors++;
      $display("FAIL beat20 got %b want %b",
               {io.sout_valid, io.sout}, {1'b1, d[20]});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({io.sout, io.sout_valid, io.busy, io.done} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 0000",
               {io.sout, io.sout_valid, io.busy, io.done});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({io.sout_valid, io.busy, io.done} !== 3'b0) begin
        errors++;
        $display("FAIL post_reset_idle got %b want 000",
                 {io.sout_valid, io.busy, io.done});
      end
    end
    stream(d, d, 0, -1, -1, bits, nb, nd, de);
    check_frame("reset_refill", d, bits, nb, nd);
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    logic [63:0]  bits;
    int nb, nd, de;
    d = 58'h2AA_AAAA_AAAA_AAAA;
    stream(d, d, 0, -1, -1, bits, nb, nd, de);
    check_frame("basic", d, bits, nb, nd);
    checks++;
    if (de !== DONE_EDGE) begin
      errors++;
      $display("FAIL basic_done_edge got %0d want %0d", de, DONE_EDGE);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    logic [63:0]  bits;
    int nb, nd, de;
    d = 58'h3FF_0000_FFFF_0001;
    stream(d, d, 1, -1, -1, bits, nb, nd, de);
    check_frame("backpressure", d, bits, nb, nd);
  endtask

  task automatic test_bus_change();
    logic [63:0] bits;
    int nb, nd, de;
    stream(58'h1, 58'h3FF_FFFF_FFFF_FFFF, 0, -1, -1, bits, nb, nd, de);
    check_frame("bus_change", 58'h1, bits, nb, nd);
  endtask

  task automatic test_start_busy();
    logic [W-1:0] d;
    logic [63:0]  bits;
    int nb, nd, de;
    int k;
    d = 58'h123_4567_89AB_CDEF;
    stream(d, d, 0, 5, 40, bits, nb, nd, de);
    check_frame("start_busy", d, bits, nb, nd);
    checks++;
    if (io.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_busy_no_requeue got %b want 0", io.busy);
    end
    io.dst = d;
    io.start = 1'b1;
    k = 0;
    while (io.done !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (io.done !== 1'b1) begin
      errors++;
      $display("FAIL held_first_done got %b want 1", io.done);
    end
    @(posedge clk); #1;
    checks++;
    if (io.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_gap got %b want 0", io.busy);
    end
    @(posedge clk); #1;
    io.start = 1'b0;
    checks++;
    if (io.busy !== 1'b1) begin
      errors++;
      $display("FAIL held_restart got %b want 1", io.busy);
    end
    k = 0;
    while (io.done !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (io.done !== 1'b1) begin
      errors++;
      $display("FAIL held_second_done got %b want 1", io.done);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_parity();
    logic [63:0] bits;
    int nb, nd, de;
    stream(58'h7, 58'h7, 0, -1, -1, bits, nb, nd, de);
    check_frame("parity7", 58'h7, bits, nb, nd);
`ifdef RESULT_SERIALIZER_PARITY_EN
    checks++;
    if (bits[58] !== 1'b1) begin
      errors++;
      $display("FAIL parity7_beat got %b want 1", bits[58]);
    end
`endif
    stream(58'h3, 58'h3, 0, -1, -1, bits, nb, nd, de);
    check_frame("parity3", 58'h3, bits, nb, nd);
`ifdef RESULT_SERIALIZER_PARITY_EN
    checks++;
    if (bits[58] !== 1'b0) begin
      errors++;
      $display("FAIL parity3_beat got %b want 0", bits[58]);
    end
`endif
    checks++;
    if (de !== DONE_EDGE) begin
      errors++;
      $display("FAIL parity_done_edge got %0d want %0d", de, DONE_EDGE);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bus_change();
    test_start_busy();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
